// File: rtl/modport_ram.sv
// ============================================================================
// Module   : modport_ram
// Purpose  : Simple dual-port RAM, one clock, registered read, clearable.
//            Optional MODPORT_RAM_WR_FWD_EN selects write-first on collision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modport_ram #(
  parameter int DEPTH  = 16,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enbl,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_enbl,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  localparam logic [AWIDTH:0] c_DEPTH = DEPTH[AWIDTH:0];

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rd_data;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_collide;
  logic [DWIDTH-1:0] w_rd_word;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  assign w_wr_ok   = wr_enbl && ({1'b0, wr_addr} < c_DEPTH);
  assign w_rd_ok   = {1'b0, rd_addr} < c_DEPTH;
  assign w_collide = w_wr_ok && (wr_addr == rd_addr);

  always_comb begin
    w_rd_word = '0;
    if (w_rd_ok) begin
`ifdef MODPORT_RAM_WR_FWD_EN
      w_rd_word = w_collide ? wr_data : r_mem[rd_addr];
`else
      w_rd_word = r_mem[rd_addr];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (rd_enbl) begin
      r_rd_data <= w_rd_word;
    end
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_modport_ram.sv
// ============================================================================
// Module   : tb_modport_ram
// Purpose  : Directed vector table plus randomized traffic for modport_ram,
//            on a power-of-2 instance and a DEPTH=12 instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modport_ram;

`ifdef MODPORT_RAM_WR_FWD_EN
  localparam bit c_FWD = 1'b1;
`else
  localparam bit c_FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_enbl;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_enbl;
  logic [3:0] rd_addr;
  logic [7:0] rd_a;
  logic [7:0] rd_b;

  always #5 clk = ~clk;

  modport_ram #(.DEPTH(16), .DWIDTH(8), .AWIDTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .wr_enbl(wr_enbl), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_enbl(rd_enbl), .rd_addr(rd_addr), .rd_data(rd_a)
  );

  modport_ram #(.DEPTH(12), .DWIDTH(8), .AWIDTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .wr_enbl(wr_enbl), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_enbl(rd_enbl), .rd_addr(rd_addr), .rd_data(rd_b)
  );

  typedef struct {
    logic       rst;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference: per-instance memory image and expected read register.
  logic [7:0] m_mem [2][16];
  logic [7:0] m_rd  [2];
  int         m_dep [2] = '{16, 12};

  function automatic void add(input logic r, input logic we, input int wa,
                              input int wd, input logic re, input int ra,
                              input logic chk, input int exp);
    vec_t v;
    v.rst = r;  v.we = we; v.wa = wa[3:0]; v.wd = wd[7:0];
    v.re  = re; v.ra = ra[3:0]; v.chk = chk; v.exp = exp[7:0];
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", name, got, exp);
    else
      n_pass++;
  endtask

  // Old contents are read first, then the write lands; collisions forward
  // the new data only in the write-first build.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) m_mem[k][i] = 8'h00;
        m_rd[k] = 8'h00;
      end else begin
        if (rd_enbl) begin
          if (int'(rd_addr) >= m_dep[k])
            m_rd[k] = 8'h00;
          else if (c_FWD && wr_enbl && wr_addr == rd_addr)
            m_rd[k] = wr_data;
          else
            m_rd[k] = m_mem[k][rd_addr];
        end
        if (wr_enbl && int'(wr_addr) < m_dep[k])
          m_mem[k][wr_addr] = wr_data;
      end
    end
  endtask

  task automatic drive_cycle(input logic r, input logic we, input logic [3:0] wa,
                             input logic [7:0] wd, input logic re,
                             input logic [3:0] ra);
    @(negedge clk);
    rst = r; wr_enbl = we; wr_addr = wa; wr_data = wd;
    rd_enbl = re; rd_addr = ra;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_enbl = 1'b0; wr_addr = '0; wr_data = '0;
    rd_enbl = 1'b0; rd_addr = '0;

    // Reset for two cycles, then every location reads zero.
    add(1, 0, 0, 0, 0, 0, 1, 8'h00);
    add(1, 1, 4, 8'h77, 1, 4, 1, 8'h00);
    for (int i = 0; i < 16; i++) add(0, 0, 0, 0, 1, i, 1, 8'h00);
    // Single write then read.
    add(0, 1, 3, 8'hA5, 0, 0, 1, 8'h00);
    add(0, 0, 0, 0, 1, 3, 1, 8'hA5);
    // Full sweep: write, then back-to-back reads.
    for (int i = 0; i < 16; i++) add(0, 1, i, i + 8'h10, 0, 0, 1, 8'hA5);
    for (int i = 0; i < 16; i++) add(0, 0, 0, 0, 1, i, 1, i + 8'h10);
    // Collision on address 7.
    add(0, 1, 7, 8'h11, 0, 0, 1, 8'h1F);
    add(0, 1, 7, 8'h22, 1, 7, 1, c_FWD ? 8'h22 : 8'h11);
    add(0, 0, 0, 0, 1, 7, 1, 8'h22);
    // Hold while disabled, even across a write to the same address.
    add(0, 1, 2, 8'h5A, 0, 0, 1, 8'h22);
    add(0, 0, 0, 0, 1, 2, 1, 8'h5A);
    add(0, 1, 2, 8'hFF, 0, 2, 1, 8'h5A);
    add(0, 0, 0, 0, 0, 2, 1, 8'h5A);
    add(0, 0, 0, 0, 1, 2, 1, 8'hFF);
    // Reset mid-traffic: the concurrent write is lost, memory is cleared.
    add(1, 1, 5, 8'h33, 1, 2, 1, 8'h00);
    add(0, 0, 0, 0, 1, 5, 1, 8'h00);
    add(0, 0, 0, 0, 1, 3, 1, 8'h00);
    add(0, 1, 5, 8'h44, 1, 5, 1, c_FWD ? 8'h44 : 8'h00);
    add(0, 0, 0, 0, 1, 5, 1, 8'h44);

    foreach (vecs[n]) begin
      drive_cycle(vecs[n].rst, vecs[n].we, vecs[n].wa, vecs[n].wd,
                  vecs[n].re, vecs[n].ra);
      if (vecs[n].chk) check($sformatf("vec%0d_a", n), rd_a, vecs[n].exp);
      check($sformatf("vec%0d_b", n), rd_b, m_rd[1]);
    end

    // Randomized traffic, both instances against the reference.
    for (int n = 0; n < 600; n++) begin
      drive_cycle(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom),
                  8'($urandom), 1'($urandom), 4'($urandom));
      check($sformatf("rnd%0d_a", n), rd_a, m_rd[0]);
      check($sformatf("rnd%0d_b", n), rd_b, m_rd[1]);
    end

    // Out-of-range on the DEPTH=12 instance: write ignored, read zero.
    drive_cycle(1'b0, 1'b1, 4'd13, 8'hC3, 1'b0, 4'd0);
    drive_cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd13);
    check("oor_rd_b", rd_b, 8'h00);
    check("oor_rd_a", rd_a, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
